// File: rtl/pedestal_recovery_pkg.sv
// Shared state encoding, register map and fixed-point widths for the pedestal recovery bank.
package pedestal_recovery_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_BYPASS = 2'd1,
    ST_PRIME  = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_COEF  = 2'd0;
  localparam logic [1:0] ADDR_SHIFT = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

  localparam int COEF_W    = 18;
  localparam int COEF_FRAC = 16;
  localparam int SHIFT_W   = 4;
  localparam int GUARD_W   = 2;

endpackage

// File: rtl/pedestal_recovery_bank_if.sv
// Configuration bus of the pedestal recovery bank: write strobe, address, data and pending flag.
interface pedestal_recovery_bank_if;

  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_pending;

  modport master (output cfg_wr, output cfg_addr, output cfg_wdata, input cfg_pending);
  modport slave  (input cfg_wr, input cfg_addr, input cfg_wdata, output cfg_pending);

endinterface

// File: rtl/pedestal_recovery_lane.sv
// One filtered lane: baseline tracker b, leaky high-pass state h, saturating output y.
module pedestal_recovery_lane
  import pedestal_recovery_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  state_e                    i_state,
  input  logic                      i_hpf_clr,
  input  logic                      i_sat_clr,
  input  logic signed [COEF_W-1:0]  i_coef,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic signed [DW-1:0]      i_x,
  output logic signed [DW-1:0]      o_y,
  output logic                      o_sat
);

  localparam int IW = DW + GUARD_W;
  localparam int PW = IW + COEF_W;
  localparam logic signed [PW-1:0] P_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] clamp(input logic signed [PW-1:0] v);
    if (v > P_MAX) begin
      clamp = P_MAX[DW-1:0];
    end else if (v < P_MIN) begin
      clamp = P_MIN[DW-1:0];
    end else begin
      clamp = v[DW-1:0];
    end
  endfunction

  function automatic logic is_ovf(input logic signed [PW-1:0] v);
    is_ovf = (v > P_MAX) || (v < P_MIN);
  endfunction

  logic signed [IW-1:0] r_b, r_h;
  logic signed [DW-1:0] r_y;
  logic                 r_sat;
  logic signed [IW-1:0] w_x_ext, w_d, w_step, w_h_next, w_sum;
  logic signed [PW-1:0] w_h_pw, w_coef_pw, w_prod, w_prod_sh, w_sum_pw;
  logic signed [DW-1:0] w_fb, w_y_run;
  logic                 w_ovf;

  // RUN-state arithmetic; the feedback product is clamped before it re-enters h
  always_comb begin
    w_x_ext   = {{GUARD_W{i_x[DW-1]}}, i_x};
    w_d       = w_x_ext - r_b;
    w_step    = w_d >>> i_shift;
    w_h_pw    = {{COEF_W{r_h[IW-1]}}, r_h};
    w_coef_pw = {{IW{i_coef[COEF_W-1]}}, i_coef};
    w_prod    = w_h_pw * w_coef_pw;
    w_prod_sh = w_prod >>> COEF_FRAC;
    w_fb      = clamp(w_prod_sh);
    if (i_hpf_clr) begin
      w_h_next = {IW{1'b0}};
    end else begin
      w_h_next = w_d + {{GUARD_W{w_fb[DW-1]}}, w_fb};
    end
    w_sum    = w_h_next + r_b;
    w_sum_pw = {{COEF_W{w_sum[IW-1]}}, w_sum};
    w_y_run  = clamp(w_sum_pw);
    w_ovf    = (is_ovf(w_prod_sh) & ~i_hpf_clr) | is_ovf(w_sum_pw);
  end

  // Per-state update of baseline, HPF state and registered output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b <= {IW{1'b0}};
      r_h <= {IW{1'b0}};
      r_y <= {DW{1'b0}};
    end else begin
      case (i_state)
        ST_CLEAR: begin
          r_b <= {IW{1'b0}};
          r_h <= {IW{1'b0}};
          r_y <= i_x;
        end
        ST_BYPASS: begin
          if (i_hpf_clr) begin
            r_h <= {IW{1'b0}};
          end
          r_y <= i_x;
        end
        ST_PRIME: begin
          r_b <= w_x_ext;
          r_h <= {IW{1'b0}};
          r_y <= i_x;
        end
        ST_RUN: begin
          r_b <= r_b + w_step;
          r_h <= w_h_next;
          r_y <= w_y_run;
        end
        default: begin
          r_y <= i_x;
        end
      endcase
    end
  end

  // Sticky saturation flag; a clear request wins over a same-cycle saturation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat <= 1'b0;
    end else if (i_sat_clr) begin
      r_sat <= 1'b0;
    end else if ((i_state == ST_RUN) && w_ovf) begin
      r_sat <= 1'b1;
    end else begin
      r_sat <= r_sat;
    end
  end

  assign o_y   = r_y;
  assign o_sat = r_sat;

endmodule

// File: rtl/pedestal_recovery_bank.sv
// Bank of AFE lanes with pedestal (baseline) removal; shadowed configuration committed only while idle.
module pedestal_recovery_bank
  import pedestal_recovery_pkg::*;
#(
  parameter int N_AFE = 5,
  parameter int N_CH  = 9,
  parameter int DW    = 16,
  parameter logic [N_AFE*N_CH-1:0] FILTER_MASK = {N_AFE{{1'b0, {(N_CH-1){1'b1}}}}}
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       hpf_clr,
  input  logic [N_AFE*N_CH*DW-1:0]   x,
  output logic [N_AFE*N_CH*DW-1:0]   y,
  pedestal_recovery_bank_if.slave    cfg,
  output logic                       busy,
  output logic [N_AFE*N_CH-1:0]      sat_sticky
);

  localparam int N_LANES = N_AFE * N_CH;

  state_e                     r_state, w_state_next;
  logic                       r_busy, r_pending, r_commit_req, r_sat_clr;
  logic signed [COEF_W-1:0]   r_coef_shadow, r_coef_act, w_coef_next;
  logic        [SHIFT_W-1:0]  r_shift_shadow, r_shift_act, w_shift_next;
  logic                       w_wr_coef, w_wr_shift, w_wr_ctrl, w_commit_req, w_commit_ok;
  logic        [13:0]         w_unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_PRIME) || (w_state_next == ST_RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR:  w_state_next = ST_BYPASS;
      ST_BYPASS: w_state_next = en ? ST_PRIME : ST_BYPASS;
      ST_PRIME:  w_state_next = en ? ST_RUN : ST_BYPASS;
      ST_RUN:    w_state_next = en ? ST_RUN : ST_BYPASS;
      default:   w_state_next = ST_CLEAR;
    endcase
  end

  // A write landing in the commit cycle is forwarded so it joins the commit
  always_comb begin
    w_wr_coef      = cfg.cfg_wr && (cfg.cfg_addr == ADDR_COEF);
    w_wr_shift     = cfg.cfg_wr && (cfg.cfg_addr == ADDR_SHIFT);
    w_wr_ctrl      = cfg.cfg_wr && (cfg.cfg_addr == ADDR_CTRL);
    w_coef_next    = w_wr_coef ? cfg.cfg_wdata[COEF_W-1:0] : r_coef_shadow;
    w_shift_next   = w_wr_shift ? cfg.cfg_wdata[SHIFT_W-1:0] : r_shift_shadow;
    w_commit_req   = r_commit_req | (w_wr_ctrl & cfg.cfg_wdata[0]);
    w_commit_ok    = (r_state == ST_CLEAR) || (r_state == ST_BYPASS);
    w_unused_wdata = cfg.cfg_wdata[31:COEF_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coef_shadow  <= {COEF_W{1'b0}};
      r_coef_act     <= {COEF_W{1'b0}};
      r_shift_shadow <= {SHIFT_W{1'b0}};
      r_shift_act    <= {SHIFT_W{1'b0}};
      r_pending      <= 1'b0;
      r_commit_req   <= 1'b0;
      r_sat_clr      <= 1'b0;
    end else begin
      r_coef_shadow  <= w_coef_next;
      r_shift_shadow <= w_shift_next;
      r_sat_clr      <= w_wr_ctrl & cfg.cfg_wdata[1];
      if (w_commit_req && w_commit_ok) begin
        r_coef_act   <= w_coef_next;
        r_shift_act  <= w_shift_next;
        r_pending    <= 1'b0;
        r_commit_req <= 1'b0;
      end else begin
        r_pending    <= r_pending | w_wr_coef | w_wr_shift;
        r_commit_req <= w_commit_req;
      end
    end
  end

  assign cfg.cfg_pending = r_pending;
  assign busy            = r_busy;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    if (FILTER_MASK[k] && ((k % N_CH) != (N_CH - 1))) begin : g_filt
      pedestal_recovery_lane #(.DW(DW)) u_lane (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_state   (r_state),
        .i_hpf_clr (hpf_clr),
        .i_sat_clr (r_sat_clr),
        .i_coef    (r_coef_act),
        .i_shift   (r_shift_act),
        .i_x       (x[k*DW +: DW]),
        .o_y       (y[k*DW +: DW]),
        .o_sat     (sat_sticky[k])
      );
    end else begin : g_pass
      logic [DW-1:0] r_y;
      // Frame and unmasked lanes only delay the sample by one cycle
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_y <= {DW{1'b0}};
        end else begin
          r_y <= x[k*DW +: DW];
        end
      end
      assign y[k*DW +: DW] = r_y;
      assign sat_sticky[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_pedestal_recovery_bank.sv
// Directed self-checking bench for pedestal_recovery_bank with an integer reference model of a filtered lane.
module tb_pedestal_recovery_bank;
  import pedestal_recovery_pkg::*;

  localparam int N_AFE = 5;
  localparam int N_CH  = 9;
  localparam int DW    = 16;
  localparam int NL    = N_AFE * N_CH;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              hpf_clr;
  logic [NL*DW-1:0]  x;
  logic [NL*DW-1:0]  y;
  logic              busy;
  logic [NL-1:0]     sat_sticky;

  int checks = 0;
  int errors = 0;

  longint m_a, m_b, m_h;
  int     m_s;

  pedestal_recovery_bank_if cfg_if ();

  pedestal_recovery_bank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .hpf_clr    (hpf_clr),
    .x          (x),
    .y          (y),
    .cfg        (cfg_if),
    .busy       (busy),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [NL*DW-1:0] pack(input int vf, input int vr);
    logic [NL*DW-1:0] v;
    logic [DW-1:0]    f;
    logic [DW-1:0]    r;
    f = vf[DW-1:0];
    r = vr[DW-1:0];
    for (int k = 0; k < NL; k++) begin
      v[k*DW +: DW] = ((k % N_CH) == (N_CH - 1)) ? r : f;
    end
    return v;
  endfunction

  function automatic logic [NL-1:0] filt_mask();
    logic [NL-1:0] m;
    for (int k = 0; k < NL; k++) begin
      m[k] = ((k % N_CH) != (N_CH - 1));
    end
    return m;
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  task automatic model_step(input longint xv, input bit clr, output longint yv);
    longint d, p, hn;
    d   = xv - m_b;
    p   = sat16((m_a * m_h) >>> 16);
    hn  = clr ? 64'sd0 : d + p;
    yv  = sat16(hn + m_b);
    m_b = m_b + (d >>> m_s);
    m_h = hn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int v);
    x = pack(v, v);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_if.cfg_wr    = 1'b1;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_wdata = data;
    tick();
    cfg_if.cfg_wr    = 1'b0;
    cfg_if.cfg_wdata = 32'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; hpf_clr = 1'b0; set_x(100);
    cfg_if.cfg_wr = 1'b0; cfg_if.cfg_addr = 2'd0; cfg_if.cfg_wdata = 32'd0;
    #12;
    checks++; if (y !== pack(0, 0)) begin errors++; $display("FAIL reset_y: got %h expected 0", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cfg_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", cfg_if.cfg_pending); end
    checks++; if (sat_sticky !== '0) begin errors++; $display("FAIL reset_sticky: got %h expected 0", sat_sticky); end
    @(posedge clk); #1; reset_n = 1'b1;
    tick();
    checks++; if (y !== pack(100, 100)) begin errors++; $display("FAIL release_y: got %h expected %h", y, pack(100, 100)); end
    checks++; if (busy !== 1'b0 || cfg_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL release_flags: got busy=%b pending=%b expected 0 0", busy, cfg_if.cfg_pending); end
    tick();
    checks++; if (y !== pack(100, 100)) begin errors++; $display("FAIL bypass_y: got %h expected %h", y, pack(100, 100)); end
  endtask

  task automatic test_step();
    cfg_write(ADDR_COEF, 32'd0);
    cfg_write(ADDR_SHIFT, 32'd4);
    checks++; if (cfg_if.cfg_pending !== 1'b1) begin errors++; $display("FAIL step_pending_set: got %b expected 1", cfg_if.cfg_pending); end
    cfg_write(ADDR_CTRL, 32'd1);
    checks++; if (cfg_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL step_commit: got %b expected 0", cfg_if.cfg_pending); end
    set_x(1000); en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL step_busy: got %b expected 1", busy); end
    tick();
    checks++; if (y !== pack(1000, 1000)) begin errors++; $display("FAIL step_prime_y: got %h expected %h", y, pack(1000, 1000)); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (y !== pack(1000, 1000)) begin errors++; $display("FAIL step_run_y[%0d]: got %h expected %h", i, y, pack(1000, 1000)); end
    end
    en = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_impulse();
    longint ye, xv;
    cfg_write(ADDR_COEF, 32'h0000_C000);
    cfg_write(ADDR_SHIFT, 32'd15);
    cfg_write(ADDR_CTRL, 32'd1);
    set_x(0); en = 1'b1;
    tick(); tick();
    m_a = 49152; m_s = 15; m_b = 0; m_h = 0;
    for (int i = 0; i < 110; i++) begin
      xv = (i < 100) ? 64'sd1 : 64'sd0;
      set_x(int'(xv));
      tick();
      model_step(xv, 1'b0, ye);
      checks++; if (y !== pack(int'(ye), int'(xv))) begin errors++; $display("FAIL impulse_y[%0d]: got %h expected %h", i, y, pack(int'(ye), int'(xv))); end
      if (i == 0) begin
        checks++; if (y[DW-1:0] !== 16'd1) begin errors++; $display("FAIL impulse_first: got %0d expected 1", y[DW-1:0]); end
      end
    end
  endtask

  task automatic test_commit_run();
    longint ye;
    longint xs [8] = '{2400, 2400, 1800, 3000, 3000, 500, 500, 500};
    cfg_write(ADDR_COEF, 32'h0000_8000);
    model_step(0, 1'b0, ye);
    checks++; if (y !== pack(int'(ye), 0)) begin errors++; $display("FAIL commit_run_y0: got %h expected %h", y, pack(int'(ye), 0)); end
    cfg_write(ADDR_CTRL, 32'd1);
    model_step(0, 1'b0, ye);
    for (int i = 0; i < 3; i++) begin
      tick();
      model_step(0, 1'b0, ye);
      checks++; if (cfg_if.cfg_pending !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL commit_held[%0d]: got pending=%b busy=%b expected 1 1", i, cfg_if.cfg_pending, busy); end
    end
    en = 1'b0;
    tick();
    checks++; if (cfg_if.cfg_pending !== 1'b1) begin errors++; $display("FAIL commit_enter_bypass: got %b expected 1", cfg_if.cfg_pending); end
    cfg_write(ADDR_SHIFT, 32'd2);
    checks++; if (cfg_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL commit_applied: got %b expected 0", cfg_if.cfg_pending); end
    set_x(2000); en = 1'b1;
    tick(); tick();
    checks++; if (y !== pack(2000, 2000)) begin errors++; $display("FAIL reprime_y: got %h expected %h", y, pack(2000, 2000)); end
    m_a = 32768; m_s = 2; m_b = 2000; m_h = 0;
    for (int i = 0; i < 8; i++) begin
      set_x(int'(xs[i]));
      hpf_clr = (i == 3);
      tick();
      model_step(xs[i], (i == 3), ye);
      checks++; if (y !== pack(int'(ye), int'(xs[i]))) begin errors++; $display("FAIL model_y[%0d]: got %h expected %h", i, y, pack(int'(ye), int'(xs[i]))); end
      if (i == 2) begin
        checks++; if (y[DW-1:0] !== 16'd2050) begin errors++; $display("FAIL hand_y2: got %0d expected 2050", y[DW-1:0]); end
      end
      if (i == 3) begin
        checks++; if (y[DW-1:0] !== 16'd2081) begin errors++; $display("FAIL hpf_clr_y: got %0d expected 2081", y[DW-1:0]); end
      end
    end
    hpf_clr = 1'b0; en = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    longint ye;
    cfg_write(ADDR_COEF, 32'h0000_FFFF);
    cfg_write(ADDR_SHIFT, 32'd15);
    cfg_write(ADDR_CTRL, 32'd1);
    set_x(0); en = 1'b1;
    tick(); tick();
    m_a = 65535; m_s = 15; m_b = 0; m_h = 0;
    set_x(32767);
    tick();
    model_step(32767, 1'b0, ye);
    checks++; if (y !== pack(int'(ye), 32767)) begin errors++; $display("FAIL sat_y0: got %h expected %h", y, pack(int'(ye), 32767)); end
    checks++; if (sat_sticky !== '0) begin errors++; $display("FAIL sat_sticky_early: got %h expected 0", sat_sticky); end
    tick();
    model_step(32767, 1'b0, ye);
    checks++; if (y !== pack(32767, 32767)) begin errors++; $display("FAIL sat_clamp: got %h expected %h", y, pack(32767, 32767)); end
    checks++; if (sat_sticky !== filt_mask()) begin errors++; $display("FAIL sat_sticky_set: got %h expected %h", sat_sticky, filt_mask()); end
    for (int i = 0; i < 3; i++) begin
      tick();
      model_step(32767, 1'b0, ye);
      checks++; if (y !== pack(int'(ye), 32767)) begin errors++; $display("FAIL sat_hold[%0d]: got %h expected %h", i, y, pack(int'(ye), 32767)); end
    end
    en = 1'b0;
    tick(); tick();
    checks++; if (sat_sticky !== filt_mask()) begin errors++; $display("FAIL sat_sticky_kept: got %h expected %h", sat_sticky, filt_mask()); end
    cfg_write(ADDR_CTRL, 32'd2);
    checks++; if (sat_sticky !== filt_mask()) begin errors++; $display("FAIL sat_clr_delay: got %h expected %h", sat_sticky, filt_mask()); end
    tick();
    checks++; if (sat_sticky !== '0) begin errors++; $display("FAIL sat_clr: got %h expected 0", sat_sticky); end
  endtask

  task automatic test_reset_midrun();
    set_x(500); en = 1'b1;
    tick(); tick(); tick();
    checks++; if (y !== pack(500, 500) || busy !== 1'b1) begin errors++; $display("FAIL midrun_pre: got y=%h busy=%b expected %h 1", y, busy, pack(500, 500)); end
    cfg_write(ADDR_COEF, 32'h0000_0100);
    checks++; if (cfg_if.cfg_pending !== 1'b1) begin errors++; $display("FAIL midrun_pending: got %b expected 1", cfg_if.cfg_pending); end
    #2; reset_n = 1'b0; #1;
    checks++; if (y !== pack(0, 0)) begin errors++; $display("FAIL async_reset_y: got %h expected 0", y); end
    checks++; if (busy !== 1'b0 || cfg_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got busy=%b pending=%b expected 0 0", busy, cfg_if.cfg_pending); end
    en = 1'b0; set_x(77);
    @(posedge clk); #1; reset_n = 1'b1;
    tick();
    checks++; if (y !== pack(77, 77) || busy !== 1'b0) begin errors++; $display("FAIL restart_clear: got y=%h busy=%b expected %h 0", y, busy, pack(77, 77)); end
    tick();
    checks++; if (y !== pack(77, 77)) begin errors++; $display("FAIL restart_bypass: got %h expected %h", y, pack(77, 77)); end
    en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_prime_busy: got %b expected 1", busy); end
    tick();
    set_x(177);
    tick();
    checks++; if (y !== pack(177, 177)) begin errors++; $display("FAIL restart_run0: got %h expected %h", y, pack(177, 177)); end
    tick();
    checks++; if (y !== pack(177, 177)) begin errors++; $display("FAIL restart_coef_zero: got %h expected %h", y, pack(177, 177)); end
    en = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_step();
    test_impulse();
    test_commit_run();
    test_saturation();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
